// File: rtl/ipsum_fifo.sv
// rtl/ipsum_fifo.sv - input-psum unpacking FIFO: 16/32-bit push, 16-bit registered pop
// Optional sticky error flag err_o when IPSUM_FIFO_ERR_EN is defined.
module ipsum_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ipsum_fifo_reset_i,
    input  logic                       push_en,
    input  logic                       push_mod,
    input  logic [31:0]                push_data,
    output logic                       full,
    output logic                       room2,
    input  logic                       pop_en,
    output logic [15:0]                pop_data,
    output logic                       pop_valid,
    output logic                       empty,
`ifdef IPSUM_FIFO_ERR_EN
    output logic                       err_o,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   pop_data_q, pop_data_d;
    logic          pop_valid_q, pop_valid_d;
    logic          push16_ok, push32_ok, pop_ok;
    logic [1:0]    n_push;

    assign full  = (count_q == CW'(DEPTH));
    assign room2 = (count_q <= CW'(DEPTH - 2));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;

    // Acceptance looks only at the current occupancy; a same-cycle pop frees nothing.
    assign push16_ok = push_en & ~push_mod & ~full;
    assign push32_ok = push_en &  push_mod & room2;
    assign pop_ok    = pop_en & ~empty;
    assign n_push    = {push32_ok, push16_ok};

`ifdef IPSUM_FIFO_ERR_EN
    logic err_q, err_d;
    assign err_o = err_q;
`endif

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        count_d     = count_q + CW'(n_push) - CW'(pop_ok);
`ifdef IPSUM_FIFO_ERR_EN
        err_d = err_q | (push_en & ~push16_ok & ~push32_ok) | (pop_en & empty);
`endif
        if (ipsum_fifo_reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pop_data_d = '0;
`ifdef IPSUM_FIFO_ERR_EN
            err_d = 1'b0;
`endif
        end else begin
            if (push16_ok) begin
                mem_d[wr_ptr_q] = push_data[15:0];
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (push32_ok) begin
                mem_d[wr_ptr_q]          = push_data[15:0];
                mem_d[wr_ptr_q + AW'(1)] = push_data[31:16];
                wr_ptr_d                 = wr_ptr_q + AW'(2);
            end
            if (pop_ok) begin
                pop_data_d  = mem_q[rd_ptr_q];
                rd_ptr_d    = rd_ptr_q + AW'(1);
                pop_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef IPSUM_FIFO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`endif

endmodule

// File: doc/ipsum_fifo.md
# ipsum_fifo

Input-psum unpacking FIFO in the CONV unit; the load-side counterpart of the output-psum packing FIFO. It accepts 16-bit single pushes or 32-bit word pushes from the psum buffer read path. It delivers 16-bit partial sums one per pop to the PE array for accumulation. Storage is a small circular buffer of 16-bit entries with a registered read port.

## Interface
- DEPTH, 4, number of 16-bit entries; power of two, ≥ 2
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ipsum_fifo_reset_i  input  1  synchronous clear of pointers, count, storage, outputs
- push_en  input  1  push request
- push_mod  input  1  0: push push_data[15:0]; 1: push both halves, [15:0] first then [31:16]
- push_data  input  32  push payload
- full  output  1  count == DEPTH
- room2  output  1  count ≤ DEPTH-2 (32-bit push acceptable)
- pop_en  input  1  pop request, one 16-bit element
- pop_data  output  16  registered popped element
- pop_valid  output  1  pop_data updated by a pop accepted in previous cycle
- empty  output  1  count == 0
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: mem[0..DEPTH-1] of 16 bits; wr_ptr, rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push acceptance is based on current count only; a same-cycle pop does not free space:
  - 16-bit push is accepted iff push_en & push_mod==0 & !full. It writes mem[wr_ptr] and advances wr_ptr by 1.
  - 32-bit push is accepted iff push_en & push_mod==1 & room2. It writes low half to mem[wr_ptr] and high half to mem[wr_ptr+1], each modulo DEPTH, and advances wr_ptr by 2.
  - Rejected pushes change nothing. There is no partial 32-bit write.
- Pop is accepted iff pop_en & !empty. pop_data <= mem[rd_ptr], and rd_ptr advances by 1. A pop on empty is ignored: pop_valid goes to 0 and pop_data holds.
- count_next = count + pushed(0/1/2) − popped(0/1). Simultaneous push and pop are both applied.
- Element order out equals element order in. Within a word, the low half comes out before the high half.
- Clear: ipsum_fifo_reset_i has priority over push and pop. It zeroes wr_ptr, rd_ptr, count, all mem entries, pop_data and pop_valid.
- Async reset (rst_n low) sets the same values as clear, immediately. It aborts any in-flight operation.

## Timing
- Reset values: full=0, room2=1, empty=1, count=0, pop_data=0, pop_valid=0 (error flag 0 if present).
- full, room2, empty and count are combinational from the count register and reflect state after the last edge.
- Push-to-pop latency:
  - A push at edge N makes the element poppable in the cycle after N.
  - A pop accepted at edge N+1 presents the element on pop_data after edge N+1, with pop_valid=1 for that one cycle.
- Back-to-back pops deliver one element per cycle. pop_valid stays high continuously while pops are accepted.
- Wrap-around: with DEPTH=4 and wr_ptr=3, a 32-bit push writes mem[3]=low and mem[0]=high; wr_ptr becomes 1.

## Configuration
- IPSUM_FIFO_ERR_EN:
  - When defined, adds output err_o (1 bit, registered). It is set on any rejected push or any pop on empty. It is sticky and cleared only by rst_n or ipsum_fifo_reset_i.
  - When undefined, the port and its logic are absent and the behaviour is otherwise identical.

## Test plan
- Reset, then 32-bit push of 0xBBBB_AAAA, then pop ×2:
  - after the push, count=2;
  - pop_data=0xAAAA then 0xBBBB with pop_valid high on both cycles;
  - then empty=1.
- Fill with 16-bit pushes 1,2,3 (count=3, room2=0):
  - a 32-bit push of 0x5555_4444 is rejected and count stays 3;
  - a 16-bit push of 4 then sets full=1.
- Wrap: push 1,2,3 (16-bit), pop 1,2,3, then 32-bit push 0x0006_0005:
  - mem[3]=5 and mem[0]=6;
  - pops return 5 then 6.
- Simultaneous: count=2 holding 7,8, push 16-bit 9 with pop_en in the same cycle:
  - count stays 2;
  - pop_data=7, and subsequent pops return 8 then 9.
- Pop on empty → pop_valid=0, pop_data unchanged, count 0. With IPSUM_FIFO_ERR_EN, err_o=1 until ipsum_fifo_reset_i.
- Clear and async reset mid-stream:
  - assert ipsum_fifo_reset_i with count=3 and push_en=1 → next cycle count=0, empty=1, pop_data=0, and the push is discarded;
  - repeat with rst_n low mid-cycle → outputs reset immediately.
